ysyx_220066_mdu_seq: RTL and testbench
======================================

# ysyx_220066_mdu_seq

Multi-cycle multiply/divide sequencer for the RV64M extension. It sits beside the single-cycle ALU in EX and takes ops that ID marks `is_Multi` or `is_Div`. It runs an iterative shift-add multiplier or a restoring divider under an FSM, applies sign and special-case fixups, and holds the result until EX consumes it. While it is occupied, `busy` drives the pipeline `block`.

## Interface
- `XLEN`, default 64: operand/result width.
- `clk` in 1: clock.
- `rst` in 1: reset, synchronous, active-low; clock `clk`.
- `flush` in 1: kill the in-flight op (trap/redirect).
- `in_valid` in 1: op request.
- `in_ready` out 1: `state==IDLE && rst`.
- `op` in 3: funct3. 000 mul, 001 mulh, 010 mulhsu, 011 mulhu, 100 div, 101 divu, 110 rem, 111 remu.
- `word` in 1: *W variant (OP 01110).
- `src1`, `src2` in XLEN: rs1, rs2.
- `out_valid` out 1: result available.
- `out_ready` in 1: EX consumes the result.
- `result` out XLEN: registered result.
- `busy` out 1: `state!=IDLE`; feeds `block`.

## Operation
- States: IDLE, MUL, DIV, FIXUP, DONE.
- Accept: `in_valid && in_ready && !flush`.
- On accept:
  - Latch `op` and `word`.
  - Word ops use `src[31:0]`; a signed word op sign-extends from bit 31.
  - Signed operands become absolute values; record `neg_res` (quotient/product sign) and `neg_rem` (dividend sign).
  - Load the 7-bit counter with N-1: N=64, or N=32 when `word`.
- Divider special cases resolve on accept and go IDLE→DONE directly:
  - Divide by zero: quotient all ones, remainder = dividend.
  - Signed overflow (most-negative / -1): quotient = dividend, remainder 0.
- MUL: one shift-add step per cycle into a 2*XLEN accumulator. mulh/mulhsu/mulhu return bits [127:64]; mul returns [63:0].
- DIV: one restoring step per cycle, using the quotient/remainder shift pair.
- MUL/DIV → FIXUP when the counter reaches 0; the counter is decremented otherwise.
- FIXUP:
  - Conditional two's-complement negate.
  - Select quotient or remainder.
  - Word ops: sign-extend bit 31 to 64 bits.
  - Then → DONE.
- DONE: `out_valid=1`, `result` stable; → IDLE when `out_ready`.
- `word` with op 001/010/011 is never issued by ID; it is treated as mul.
- `flush` overrides everything: next state is IDLE and `out_valid` is cleared. A flush in the same cycle as `in_valid` does not accept the op.
- Reset (`rst` low at a clock edge), including mid-operation: state IDLE, `out_valid` 0, `result` 0, counter 0, `busy` 0. `in_ready` is 0 while `rst` is low.

## Timing
- Accept edge = end of cycle 0.
- Iterative ops: iteration cycles 1..N, FIXUP in cycle N+1, `out_valid` from cycle N+2.
  - 64-bit: `out_valid` at cycle 66.
  - Word: `out_valid` at cycle 34.
- Special-case divide: `out_valid` at cycle 1.
- Back-to-back: the DONE→IDLE handoff costs one cycle. The next accept is at the earliest in the cycle after `out_ready` is sampled.
- `out_valid` holds until `out_ready`; `result` does not change while `out_valid` is high.

## Configuration
- `YSYX_220066_MDU_FAST_MUL_EN`
  - Defined: MUL state is skipped. A signed 65x65 `*` product is registered in FIXUP, giving `out_valid` at cycle 2 for all multiplies.
  - Undefined: 64/32-cycle shift-add as above.
- Division behaviour is identical either way.

## Structure
- Shared package `ysyx_220066_pkg` holds:
  - funct3 op encodings (`MDU_MUL` … `MDU_REMU`);
  - the state encoding;
  - `MDU_ITER_64=63` and `MDU_ITER_32=31`.
- Sub-module `ysyx_220066_div_step`: combinational, one restoring-division step. Inputs: partial remainder, dividend bit, divisor. Outputs: new remainder and quotient bit.
- The FSM, counter, sign logic and fixup stay in the top module.

## Test plan
- mul, `src1=3`, `src2=-2` → `result=0xFFFF_FFFF_FFFF_FFFA`, `out_valid` at cycle 66 (cycle 2 with FAST_MUL_EN).
- mulh -1×-1 → 0.
- mulhu `0xFFFF_FFFF_FFFF_FFFF`×2 → 1.
- mulhsu -1×2 → `0xFFFF_FFFF_FFFF_FFFF`.
- div 7/-2 → `0xFFFF_FFFF_FFFF_FFFD`.
- rem 7/-2 → 1.
- remw `src1=0xFFFF_FFFF_FFFF_FFF9`, `src2=2` → `0xFFFF_FFFF_FFFF_FFFF`, `out_valid` at cycle 34.
- divu by 0 → all ones at cycle 1; remu `src1=0x1234` by 0 → `0x1234`.
- divw `0x8000_0000`/`0xFFFF_FFFF` → `0xFFFF_FFFF_8000_0000`, at cycle 1.
- Hold `out_ready=0` for 5 cycles in DONE → `result` stable, `in_ready=0`, `busy=1`.
- Assert `flush` at cycle 20 of a div → IDLE at cycle 21, no `out_valid`.
- Assert `flush` together with `in_valid` → not accepted.
- Drop `rst` during DIV → all outputs 0, `in_ready` returns 1 the cycle after `rst` goes high.

Source files
------------

// File: rtl/ysyx_220066_pkg.sv
// Shared MDU definitions: funct3 op encodings, sequencer state encoding, iteration counts.
package ysyx_220066_pkg;
  localparam logic [2:0] MDU_MUL    = 3'b000;
  localparam logic [2:0] MDU_MULH   = 3'b001;
  localparam logic [2:0] MDU_MULHSU = 3'b010;
  localparam logic [2:0] MDU_MULHU  = 3'b011;
  localparam logic [2:0] MDU_DIV    = 3'b100;
  localparam logic [2:0] MDU_DIVU   = 3'b101;
  localparam logic [2:0] MDU_REM    = 3'b110;
  localparam logic [2:0] MDU_REMU   = 3'b111;

  localparam logic [6:0] MDU_ITER_64 = 7'd63;
  localparam logic [6:0] MDU_ITER_32 = 7'd31;

  typedef enum logic [2:0] {IDLE, MUL, DIV, FIXUP, DONE} mdu_state_e;
endpackage

// File: rtl/ysyx_220066_mdu_seq_if.sv
// Request/response bundle between EX and the multi-cycle MDU.
interface ysyx_220066_mdu_seq_if #(
  parameter int XLEN = 64
);
  logic            flush;
  logic            in_valid;
  logic            in_ready;
  logic [2:0]      op;
  logic            word;
  logic [XLEN-1:0] src1;
  logic [XLEN-1:0] src2;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] result;
  logic            busy;

  modport master (
    output flush, in_valid, op, word, src1, src2, out_ready,
    input  in_ready, out_valid, result, busy
  );
  modport slave (
    input  flush, in_valid, op, word, src1, src2, out_ready,
    output in_ready, out_valid, result, busy
  );
endinterface

// File: rtl/ysyx_220066_div_step.sv
// One restoring-division step: shift in a dividend bit, subtract divisor if it fits.
module ysyx_220066_div_step #(
  parameter int XLEN = 64
) (
  input  logic [XLEN-1:0] rem_i,
  input  logic            bit_i,
  input  logic [XLEN-1:0] dvsr_i,
  output logic [XLEN-1:0] rem_o,
  output logic            q_o
);
  logic [XLEN:0] sh, diff;

  assign sh   = {rem_i, bit_i};
  assign diff = sh - {1'b0, dvsr_i};
  // rem_i < dvsr_i keeps a successful difference below 2^XLEN, so the top bit is the borrow
  assign q_o   = ~diff[XLEN];
  assign rem_o = q_o ? diff[XLEN-1:0] : sh[XLEN-1:0];
endmodule

// File: rtl/ysyx_220066_mdu_seq.sv
// Multi-cycle RV64M sequencer: shift-add multiplier, restoring divider, sign/word fixup.
// Define YSYX_220066_MDU_FAST_MUL_EN to replace the shift-add loop with a one-cycle multiplier.
module ysyx_220066_mdu_seq
  import ysyx_220066_pkg::*;
#(
  parameter int XLEN = 64
) (
  input logic clk,
  input logic rst,
  ysyx_220066_mdu_seq_if.slave mdu
);
  localparam logic [XLEN-1:0] MIN_D = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [XLEN-1:0] MIN_W = {{(XLEN-31){1'b1}}, 31'b0};

  mdu_state_e state_q, state_d;
  logic [6:0] cnt_q;
  logic [2:0] op_q;
  logic       word_q, neg_res_q, neg_rem_q;
  logic [XLEN-1:0] result_q, quo_q, rem_q, dvsr_q;

  logic in_ready, accept, is_div, s1, s2, neg1, neg2, div_zero, div_ovf, special, step_qbit;
  logic [2:0] op_eff;
  logic [XLEN-1:0] x1, x2, abs1, abs2, spec_raw, spec_res, step_rem;
  logic [XLEN-1:0] quo_fix, rem_fix, fix_raw, fix_res;
  logic [2*XLEN-1:0] prod;

  assign in_ready      = (state_q == IDLE) && rst;
  assign accept        = mdu.in_valid && in_ready && !mdu.flush;
  assign mdu.in_ready  = in_ready;
  assign mdu.out_valid = (state_q == DONE);
  assign mdu.result    = result_q;
  assign mdu.busy      = (state_q != IDLE);

  // Request decode; word forms of mulh* are never issued and fold into mul
  always_comb begin
    op_eff = (mdu.word && !mdu.op[2]) ? MDU_MUL : mdu.op;
    is_div = op_eff[2];
    {s1, s2} = 2'b00;
    case (op_eff)
      MDU_MUL, MDU_MULH:  {s1, s2} = 2'b11;
      MDU_MULHSU:         {s1, s2} = 2'b10;
      MDU_MULHU:          {s1, s2} = 2'b00;
      MDU_DIV, MDU_REM:   {s1, s2} = 2'b11;
      MDU_DIVU, MDU_REMU: {s1, s2} = 2'b00;
      default:            {s1, s2} = 2'b00;
    endcase
    x1 = mdu.word ? {{(XLEN-32){s1 & mdu.src1[31]}}, mdu.src1[31:0]} : mdu.src1;
    x2 = mdu.word ? {{(XLEN-32){s2 & mdu.src2[31]}}, mdu.src2[31:0]} : mdu.src2;
    neg1 = s1 & x1[XLEN-1];
    neg2 = s2 & x2[XLEN-1];
    abs1 = neg1 ? -x1 : x1;
    abs2 = neg2 ? -x2 : x2;
    div_zero = is_div && (x2 == '0);
    div_ovf  = is_div && s1 && (x2 == '1) && (x1 == (mdu.word ? MIN_W : MIN_D));
    special  = div_zero || div_ovf;
    if (op_eff[1]) spec_raw = div_zero ? x1 : '0;
    else           spec_raw = div_zero ? '1 : x1;
    spec_res = mdu.word ? {{(XLEN-32){spec_raw[31]}}, spec_raw[31:0]} : spec_raw;
  end

`ifdef YSYX_220066_MDU_FAST_MUL_EN
  logic [XLEN:0] fa_q, fb_q;
  always_ff @(posedge clk) begin
    if (accept) begin
      fa_q <= {s1 & x1[XLEN-1], x1};
      fb_q <= {s2 & x2[XLEN-1], x2};
    end
  end
  // Truncated product of sign-extended operands equals the signed 65x65 product mod 2^128
  assign prod = {{(XLEN-1){fa_q[XLEN]}}, fa_q} * {{(XLEN-1){fb_q[XLEN]}}, fb_q};
`else
  logic [2*XLEN-1:0] acc_q, mcand_q;
  logic [XLEN-1:0]   mplier_q;
  always_ff @(posedge clk) begin
    if (accept) begin
      acc_q    <= '0;
      mcand_q  <= {{XLEN{1'b0}}, abs1};
      mplier_q <= abs2;
    end else if (state_q == MUL) begin
      if (mplier_q[0]) acc_q <= acc_q + mcand_q;
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
    end
  end
  assign prod = neg_res_q ? -acc_q : acc_q;
`endif

  ysyx_220066_div_step #(.XLEN(XLEN)) u_step (
    .rem_i (rem_q),
    .bit_i (quo_q[XLEN-1]),
    .dvsr_i(dvsr_q),
    .rem_o (step_rem),
    .q_o   (step_qbit)
  );

  // Word dividends are pre-shifted so 32 steps leave the quotient in the low half
  always_ff @(posedge clk) begin
    if (accept) begin
      op_q      <= op_eff;
      word_q    <= mdu.word;
      neg_res_q <= neg1 ^ neg2;
      neg_rem_q <= neg1;
      rem_q     <= '0;
      dvsr_q    <= abs2;
      quo_q     <= mdu.word ? {abs1[31:0], {(XLEN-32){1'b0}}} : abs1;
    end else if (state_q == DIV) begin
      rem_q <= step_rem;
      quo_q <= {quo_q[XLEN-2:0], step_qbit};
    end
  end

  always_comb begin
    quo_fix = neg_res_q ? -quo_q : quo_q;
    rem_fix = neg_rem_q ? -rem_q : rem_q;
    if (op_q[2]) fix_raw = op_q[1] ? rem_fix : quo_fix;
    else         fix_raw = (op_q == MDU_MUL) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
    fix_res = word_q ? {{(XLEN-32){fix_raw[31]}}, fix_raw[31:0]} : fix_raw;
  end

  always_ff @(posedge clk) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (accept) begin
        if (special)     state_d = DONE;
        else if (is_div) state_d = DIV;
`ifdef YSYX_220066_MDU_FAST_MUL_EN
        else             state_d = FIXUP;
`else
        else             state_d = MUL;
`endif
      end
      MUL, DIV: if (cnt_q == 7'd0) state_d = FIXUP;
      FIXUP:    state_d = DONE;
      DONE:     if (mdu.out_ready) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
    if (mdu.flush) state_d = IDLE;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q    <= 7'd0;
      result_q <= '0;
    end else begin
      case (state_q)
        IDLE: if (accept) begin
          cnt_q <= mdu.word ? MDU_ITER_32 : MDU_ITER_64;
          if (special) result_q <= spec_res;
        end
        MUL, DIV: if (cnt_q != 7'd0) cnt_q <= cnt_q - 7'd1;
        FIXUP:    result_q <= fix_res;
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_ysyx_220066_mdu_seq.sv
// Directed + randomized bench for the MDU sequencer against an arithmetic reference model.
module tb_ysyx_220066_mdu_seq;
  import ysyx_220066_pkg::*;

`ifdef YSYX_220066_MDU_FAST_MUL_EN
  localparam int ML64 = 2, ML32 = 2;
`else
  localparam int ML64 = 66, ML32 = 34;
`endif

  logic clk, rst;
  int total = 0, bad = 0;

  ysyx_220066_mdu_seq_if #(.XLEN(64)) m();
  ysyx_220066_mdu_seq #(.XLEN(64)) dut (.clk(clk), .rst(rst), .mdu(m));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] sx32(input logic [31:0] v);
    return {{32{v[31]}}, v};
  endfunction

  // RISC-V M semantics from plain arithmetic
  function automatic logic [63:0] ref_mdu(input logic [2:0] op, input logic w,
                                          input logic [63:0] a, input logic [63:0] b);
    longint sa, sb; longint unsigned ua, ub;
    int sa32, sb32, r32s; int unsigned ua32, ub32;
    logic [127:0] p; logic [31:0] r32;
    sa = a; sb = b; ua = a; ub = b;
    sa32 = a[31:0]; sb32 = b[31:0]; ua32 = a[31:0]; ub32 = b[31:0];
    if (!op[2]) begin
      if (w) begin r32 = ua32 * ub32; return sx32(r32); end
      case (op[1:0])
        2'd0: return a * b;
        2'd1: p = {{64{a[63]}}, a} * {{64{b[63]}}, b};
        2'd2: p = {{64{a[63]}}, a} * {64'd0, b};
        default: p = {64'd0, a} * {64'd0, b};
      endcase
      return p[127:64];
    end
    if (w) begin
      case (op[1:0])
        2'd0: r32s = (sb32 == 0) ? -1 : (sa32 == 32'sh8000_0000 && sb32 == -1) ? sa32 : sa32 / sb32;
        2'd1: r32s = (ub32 == 0) ? -1 : int'(ua32 / ub32);
        2'd2: r32s = (sb32 == 0) ? sa32 : (sa32 == 32'sh8000_0000 && sb32 == -1) ? 0 : sa32 % sb32;
        default: r32s = (ub32 == 0) ? int'(ua32) : int'(ua32 % ub32);
      endcase
      r32 = r32s;
      return sx32(r32);
    end
    case (op[1:0])
      2'd0: return (b == 0) ? '1 : (a == 64'h8000_0000_0000_0000 && b == '1) ? a : sa / sb;
      2'd1: return (b == 0) ? '1 : ua / ub;
      2'd2: return (b == 0) ? a : (a == 64'h8000_0000_0000_0000 && b == '1) ? 64'd0 : sa % sb;
      default: return (b == 0) ? a : ua % ub;
    endcase
  endfunction

  function automatic int ref_lat(input logic [2:0] op, input logic w,
                                 input logic [63:0] a, input logic [63:0] b);
    bit zero, ovf;
    if (!op[2]) return w ? ML32 : ML64;
    zero = w ? (b[31:0] == 32'd0) : (b == 64'd0);
    ovf  = !op[0] && (w ? (a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF)
                        : (a == 64'h8000_0000_0000_0000 && b == '1));
    return (zero || ovf) ? 1 : (w ? 34 : 66);
  endfunction

  function automatic logic [63:0] pick();
    case ($urandom_range(0, 6))
      0: return 64'd0;
      1: return '1;
      2: return 64'h8000_0000_0000_0000;
      3: return 64'h0000_0000_8000_0000;
      4: return {32'd0, 32'($urandom_range(0, 20))};
      default: return {$urandom, $urandom};
    endcase
  endfunction

  task automatic run_op(input string tag, input logic [2:0] op, input logic w,
                        input logic [63:0] a, input logic [63:0] b,
                        input logic [63:0] exp, input int elat, input int hold);
    int cyc = 0; bit got = 0;
    @(negedge clk);
    chk({tag, ".in_ready"}, {63'd0, m.in_ready}, 64'd1);
    m.in_valid = 1; m.op = op; m.word = w; m.src1 = a; m.src2 = b;
    @(posedge clk); #1;
    m.in_valid = 0; m.op = 3'($urandom); m.word = 1'($urandom);
    m.src1 = {$urandom, $urandom}; m.src2 = {$urandom, $urandom};
    while (cyc < 200 && !got) begin
      @(negedge clk); cyc++; got = m.out_valid;
    end
    chk({tag, ".lat"}, 64'(cyc), 64'(elat));
    chk({tag, ".res"}, m.result, exp);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk({tag, ".hold_res"}, m.result, exp);
      chk({tag, ".hold_vld"}, {63'd0, m.out_valid}, 64'd1);
      chk({tag, ".hold_rdy"}, {63'd0, m.in_ready}, 64'd0);
      chk({tag, ".hold_busy"}, {63'd0, m.busy}, 64'd1);
    end
    m.out_ready = 1;
    @(posedge clk); #1;
    m.out_ready = 0;
  endtask

  initial begin
    logic [2:0] rop; logic rw; logic [63:0] ra, rb;
    bit seen;
    clk = 0; rst = 0;
    m.flush = 0; m.in_valid = 0; m.op = 3'd0; m.word = 0;
    m.src1 = 64'd0; m.src2 = 64'd0; m.out_ready = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst.out_valid", {63'd0, m.out_valid}, 64'd0);
    chk("rst.result", m.result, 64'd0);
    chk("rst.busy", {63'd0, m.busy}, 64'd0);
    chk("rst.in_ready", {63'd0, m.in_ready}, 64'd0);
    rst = 1;
    @(negedge clk);
    chk("rst.release_rdy", {63'd0, m.in_ready}, 64'd1);

    run_op("mul", MDU_MUL, 0, 64'd3, 64'hFFFF_FFFF_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFA, ML64, 0);
    run_op("mulh", MDU_MULH, 0, '1, '1, 64'd0, ML64, 0);
    run_op("mulhu", MDU_MULHU, 0, '1, 64'd2, 64'd1, ML64, 0);
    run_op("mulhsu", MDU_MULHSU, 0, '1, 64'd2, '1, ML64, 0);
    run_op("div", MDU_DIV, 0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFD, 66, 0);
    run_op("rem_hold", MDU_REM, 0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 64'd1, 66, 5);
    run_op("remw", MDU_REM, 1, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, '1, 34, 0);
    run_op("divu0", MDU_DIVU, 0, 64'd99, 64'd0, '1, 1, 0);
    run_op("remu0", MDU_REMU, 0, 64'h1234, 64'd0, 64'h1234, 1, 0);
    run_op("divw_ovf", MDU_DIV, 1, 64'h8000_0000, 64'hFFFF_FFFF, 64'hFFFF_FFFF_8000_0000, 1, 0);
    run_op("div_ovf", MDU_DIV, 0, 64'h8000_0000_0000_0000, '1, 64'h8000_0000_0000_0000, 1, 0);
    run_op("mulw", MDU_MULH, 1, 64'h0001_0000, 64'h0000_8000, 64'hFFFF_FFFF_8000_0000, ML32, 0);

    // flush mid-divide
    @(negedge clk);
    m.in_valid = 1; m.op = MDU_DIV; m.word = 0; m.src1 = 64'd1000; m.src2 = 64'd7;
    @(posedge clk); #1 m.in_valid = 0;
    repeat (20) @(negedge clk);
    chk("flush.busy_before", {63'd0, m.busy}, 64'd1);
    m.flush = 1;
    @(posedge clk); #1 m.flush = 0;
    @(negedge clk);
    chk("flush.busy", {63'd0, m.busy}, 64'd0);
    chk("flush.in_ready", {63'd0, m.in_ready}, 64'd1);
    seen = 0;
    repeat (60) begin @(negedge clk); seen |= m.out_valid; end
    chk("flush.no_valid", {63'd0, seen}, 64'd0);

    // flush with request is not accepted
    @(negedge clk);
    m.in_valid = 1; m.flush = 1; m.op = MDU_DIV; m.src1 = 64'd9; m.src2 = 64'd3;
    @(posedge clk); #1 begin m.in_valid = 0; m.flush = 0; end
    @(negedge clk);
    chk("flush_req.busy", {63'd0, m.busy}, 64'd0);
    chk("flush_req.in_ready", {63'd0, m.in_ready}, 64'd1);

    // reset mid-divide (previous result is nonzero)
    run_op("pre_rst", MDU_DIVU, 0, 64'd100, 64'd9, 64'd11, 66, 0);
    @(negedge clk);
    m.in_valid = 1; m.op = MDU_DIVU; m.word = 0; m.src1 = 64'd500; m.src2 = 64'd3;
    @(posedge clk); #1 m.in_valid = 0;
    repeat (10) @(negedge clk);
    rst = 0;
    @(negedge clk);
    chk("mrst.out_valid", {63'd0, m.out_valid}, 64'd0);
    chk("mrst.result", m.result, 64'd0);
    chk("mrst.busy", {63'd0, m.busy}, 64'd0);
    chk("mrst.in_ready", {63'd0, m.in_ready}, 64'd0);
    rst = 1;
    @(negedge clk);
    chk("mrst.in_ready_back", {63'd0, m.in_ready}, 64'd1);
    run_op("post_rst", MDU_REMU, 0, 64'd500, 64'd3, 64'd2, 66, 0);

    for (int i = 0; i < 40; i++) begin
      rop = 3'($urandom); rw = 1'($urandom); ra = pick(); rb = pick();
      run_op($sformatf("rnd%0d", i), rop, rw, ra, rb, ref_mdu(rop, rw, ra, rb),
             ref_lat(rop, rw, ra, rb), $urandom_range(0, 2));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
